// File: rtl/manual_drive_ctrl.sv
// Manual-transmission drive controller: input synchronisers, hold-to-power-on
// counter and the drive state machine producing car state and motion intent.
module manual_drive_ctrl #(
   parameter int unsigned POWER_ON_CYCLES = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       power_on,
   input  logic       power_off,
   input  logic       throttle,
   input  logic       clutch,
   input  logic       brake,
   input  logic       reverse_gear,
   input  logic       turn_left,
   input  logic       turn_right,
   output logic [3:0] state,
   output logic [3:0] answer,
   output logic       power_now
);

   localparam int unsigned   CW       = $clog2(POWER_ON_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(POWER_ON_CYCLES - 1);

   typedef enum logic [3:0] {
      NOT_STARTING = 4'b0001,
      STARTING     = 4'b0010,
      MOVING       = 4'b0100,
      OFF          = 4'b1000
   } state_t;

   state_t        cur_state;
   state_t        next_state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] next_cnt;
   logic [7:0]    sync_meta;
   logic [7:0]    sync_q;
   logic          prev_reverse;
   logic [3:0]    next_answer;
   logic          next_moving;
   logic          next_active;

   logic power_on_s, power_off_s, throttle_s, clutch_s;
   logic brake_s, reverse_gear_s, turn_left_s, turn_right_s;

   assign {power_on_s, power_off_s, throttle_s, clutch_s,
           brake_s, reverse_gear_s, turn_left_s, turn_right_s} = sync_q;

   assign state = cur_state;

   always_comb begin
      next_state = cur_state;
      next_cnt   = '0;
      case (cur_state)
         OFF: begin
            if (power_on_s && !power_off_s) begin
               if (cnt == CNT_LAST) next_state = NOT_STARTING;
               else                 next_cnt   = cnt + 1'b1;
            end
         end
         NOT_STARTING: begin
            if (power_off_s)                  next_state = OFF;
            else if (brake_s)                 next_state = NOT_STARTING;
            else if (throttle_s && !clutch_s) next_state = OFF;
            else if (throttle_s && clutch_s)  next_state = STARTING;
         end
         STARTING: begin
            if (power_off_s)                  next_state = OFF;
            else if (brake_s)                 next_state = NOT_STARTING;
            else if (throttle_s && !clutch_s) next_state = MOVING;
         end
         MOVING: begin
            if (power_off_s)                                       next_state = OFF;
            else if (brake_s)                                      next_state = NOT_STARTING;
            else if ((reverse_gear_s != prev_reverse) && !clutch_s) next_state = OFF;
            else if (!throttle_s || clutch_s)                      next_state = STARTING;
         end
         default: next_state = OFF;
      endcase
   end

   // Intent is derived from the state being entered so it lines up with state.
   always_comb begin
      next_moving = (next_state == MOVING);
      next_active = next_moving || (next_state == STARTING);
      next_answer = {next_active & turn_left_s  & ~turn_right_s,
                     next_active & turn_right_s & ~turn_left_s,
                     next_moving & reverse_gear_s,
                     next_moving & ~reverse_gear_s};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_meta    <= '0;
         sync_q       <= '0;
         cur_state    <= OFF;
         cnt          <= '0;
         prev_reverse <= 1'b0;
         answer       <= '0;
         power_now    <= 1'b1;
      end else begin
         sync_meta    <= {power_on, power_off, throttle, clutch,
                          brake, reverse_gear, turn_left, turn_right};
         sync_q       <= sync_meta;
         cur_state    <= next_state;
         cnt          <= next_cnt;
         prev_reverse <= reverse_gear_s;
         answer       <= next_answer;
         power_now    <= (next_state == OFF);
      end
   end

endmodule

// File: doc/manual_drive_ctrl.md
Name: manual_drive_ctrl

Overview:
- Manual-transmission drive controller that produces the car status and motion-intent signals consumed by the turn-signal light, display and motor blocks.
- Inputs are the raw driver controls: power buttons, throttle, clutch, brake, reverse gear and turn switches.
- Outputs are the one-hot car state, the {left,right,back,forward} intent vector and the powered-off flag.
- Includes input synchronisers, a hold-to-power-on counter and the drive state machine.

Parameters:
- POWER_ON_CYCLES, 100_000_000: consecutive cycles power_on must be held (1 s at 100 MHz) to leave OFF; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- power_on  in  1  power-on button (raw, async)
- power_off  in  1  power-off button (raw, async)
- throttle  in  1  throttle switch (raw)
- clutch  in  1  clutch switch (raw)
- brake  in  1  brake switch (raw)
- reverse_gear  in  1  reverse gear switch (raw); 1 = reverse
- turn_left  in  1  left-turn switch (raw)
- turn_right  in  1  right-turn switch (raw)
- state  out  4  one-hot car state: 0001 NOT_STARTING, 0010 STARTING, 0100 MOVING, 1000 OFF
- answer  out  4  intent vector {left, right, back, forward}
- power_now  out  1  1 while state==OFF

Behaviour:
- Reset: sampled only on a rising clk edge with rst==0. Sets state=1000 (OFF), power_now=1, answer=0000, power-on counter=0, all sync flops=0, prev_reverse=0.
- Synchronisers: every raw input passes through a 2-flop synchroniser. FSM and answer logic use only synchronised values (suffix _s below).
- Latency: a raw input stable before edge k is reflected on state/answer/power_now after edge k+2. state, answer and power_now are registered and update on the same edge.
- Priority in any non-OFF state: power_off_s > brake_s > stall conditions > throttle-driven transitions.
- OFF:
  - Counter increments while power_on_s==1 and power_off_s==0; it clears to 0 otherwise.
  - When the counter reaches POWER_ON_CYCLES-1 with power_on_s still 1, the next state is NOT_STARTING and the counter clears.
  - power_on_s and power_off_s both 1: remain in OFF, counter=0.
- Any non-OFF state, power_off_s==1: next state is OFF and the counter clears. An already-held power_on does not restart power-on; the count starts fresh.
- NOT_STARTING:
  - brake_s: stay.
  - throttle_s & ~clutch_s: OFF (stall).
  - throttle_s & clutch_s: STARTING.
  - else: stay.
- STARTING:
  - brake_s: NOT_STARTING.
  - throttle_s & ~clutch_s: MOVING.
  - else: stay.
- MOVING:
  - brake_s: NOT_STARTING.
  - reverse_gear_s != prev_reverse & ~clutch_s: OFF (gear change without clutch).
  - ~throttle_s | clutch_s: STARTING.
  - else: stay.
  - prev_reverse is a register updated every cycle from reverse_gear_s in all states.
- answer is computed from the next state and the synchronised inputs:
  - forward = (next==MOVING) & ~reverse_gear_s
  - back = (next==MOVING) & reverse_gear_s
  - left = next∈{STARTING,MOVING} & turn_left_s & ~turn_right_s
  - right = next∈{STARTING,MOVING} & turn_right_s & ~turn_left_s
  - Both turn switches on gives left=right=0. In OFF and NOT_STARTING, answer=0000.
- power_now = (next==OFF).
- state is always exactly one-hot. Illegal encodings are unreachable; if one is present it recovers to OFF on the next edge.
- Counter width is clog2(POWER_ON_CYCLES). The counter never wraps because it saturates at the transition point.

Test Plan:
Use POWER_ON_CYCLES=4 in simulation.
1. Reset then power on: rst=0 for 2 edges, then release; hold power_on 6 cycles -> state=1000 and power_now=1 until 2 sync edges + 4 count edges have passed, then state=0001, power_now=0. A 3-cycle hold followed by release -> stays 1000 with the counter back at 0.
2. Drive up: from 0001 set clutch=1, throttle=1 -> 0010 three edges later. Clear clutch -> 0100, answer=0001. Set reverse_gear with clutch=1, then clear clutch -> answer=0010.
3. Stall cases: in 0001 set throttle=1, clutch=0 -> 1000, power_now=1. In 0100 toggle reverse_gear with clutch=0 -> 1000.
4. Priority: in 0100 raise brake and power_off on the same cycle -> 1000, not 0001. In 0010 with brake=1, throttle=1, clutch=0 -> 0001.
5. Turn signals: in 0100 with turn_left=1 -> answer=1001. Add turn_right=1 -> 0001. Return to 0001 with turn_left held -> answer=0000.
6. Mid-operation reset: in 0100 with answer=1001, assert rst=0 for one edge -> state=1000, answer=0000, power_now=1 on that edge. A power_on held through reset still needs a full fresh count.
